// File: rtl/regdump_pkg.sv
// Shared types and default sizes for the register-file dump streamer.
// Defining REGDUMP_CHECKSUM_EN adds the CSUM state and the trailing checksum beat.
package regdump_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
`ifdef REGDUMP_CHECKSUM_EN
        ST_CSUM  = 3'd2,
`endif
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } dump_state_e;

    typedef struct packed {
        logic                 csum;
        logic                 last;
        logic [AW_DEF-1:0]    addr;
        logic [WIDTH_DEF-1:0] data;
    } beat_t;

    function automatic int beat_bits(input int aw, input int width);
        return aw + width + 2;
    endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready beat stream carrying {csum, last, addr, data} out of the dump agent.
interface regfile_dump_if
    import regdump_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
);
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_addr;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_csum;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        output out_csum,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        input  out_csum,
        output out_ready
    );
endinterface

// File: rtl/regdump_outreg.sv
// Single-entry valid/ready output register; a load is taken only when the
// entry is empty or draining, so the payload never changes under back-pressure.
module regdump_outreg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          free_s;

    assign free_s = !valid_q || ready_i;

    // Next-state: accept a new beat, drain on transfer, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i && free_s) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/regfile_dump.sv
// Walks every register through one regfile read port and streams {addr, data} beats.
// Optional REGDUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module regfile_dump
    import regdump_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    regfile_dump_if.master   strm
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Same layout as regdump_pkg::beat_t, sized by this instance.
    typedef struct packed {
        logic             csum;
        logic             last;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } beat_w_t;

    localparam int BW = beat_bits(AW, WIDTH);

    dump_state_e   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          busy_q, done_q;
    logic          load_s, free_s, ovalid_s;
    beat_w_t       beat_s, obeat_s;

`ifdef REGDUMP_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;

    function automatic logic [WIDTH-1:0] csum_fold(input logic [WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0] word);
        return acc ^ word;
    endfunction
`endif

    assign free_s = !ovalid_s || strm.out_ready;

    // FSM next state, counter/checksum update and beat formation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        beat_s  = '0;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (free_s) begin
                    load_s      = 1'b1;
                    beat_s.addr = cnt_q;
                    beat_s.data = rd_data;
`ifdef REGDUMP_CHECKSUM_EN
                    beat_s.last = 1'b0;
                    csum_d      = csum_fold(csum_q, rd_data);
`else
                    beat_s.last = (cnt_q == LAST_ADDR);
`endif
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d = '0;
`ifdef REGDUMP_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_FLUSH;
`endif
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (free_s) begin
                    load_s      = 1'b1;
                    beat_s.csum = 1'b1;
                    beat_s.last = 1'b1;
                    beat_s.addr = '0;
                    beat_s.data = csum_q;
                    state_d     = ST_FLUSH;
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_FLUSH: begin
                if (ovalid_s && strm.out_ready) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // The read address is registered; it follows the counter only while scanning.
        rd_addr_d = (state_d == ST_SCAN) ? cnt_d : '0;
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    // Running XOR of every captured data word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    regdump_outreg #(.DW(BW)) u_outreg (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (load_s),
        .data_i  (beat_s),
        .ready_i (strm.out_ready),
        .valid_o (ovalid_s),
        .data_o  (obeat_s)
    );

    assign strm.out_valid = ovalid_s;
    assign strm.out_addr  = obeat_s.addr;
    assign strm.out_data  = obeat_s.data;
    assign strm.out_last  = obeat_s.last;
    assign strm.out_csum  = obeat_s.csum;

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_addr = rd_addr_q;
endmodule
